addsub_result_fifo: RTL

Result-capture stage sitting directly downstream of the add/sub unit in the user project. Every result the add/sub unit presents on its single-cycle completion strobe is pushed into a DEPTH-entry FIFO. The management SoC drains that FIFO through a small register-mapped bus slave. A level interrupt fires once the fill level reaches a programmable threshold.

---
 rtl/addsub_result_fifo.sv | 89 ++++++++
 1 files changed

// File: rtl/addsub_result_fifo.sv
// addsub_result_fifo: captures add/sub results into a FIFO drained by a
// register-mapped bus slave, with a programmable fill-level interrupt.
module addsub_result_fifo #(
    parameter int BITS   = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int THRESH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            res_valid,
    input  logic [BITS-1:0] res_data,
    input  logic            bus_valid,
    input  logic            bus_we,
    input  logic [3:0]      bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic            bus_ack,
    output logic [31:0]     bus_rdata,
    output logic            irq
);
    logic [BITS-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ADDR_W:0]   count;
    logic [7:0]        thresh;
    logic              overflow, underflow, irq_en;
    logic              acc, rd, wr, empty, full, pop, push, flush;
    logic [1:0]        reg_sel;
    logic [31:0]       status, ctrl, rd_val;
    logic              unused;

    assign unused = ^{bus_addr[1:0], bus_wdata[31:12]};

    always_comb begin
        reg_sel = bus_addr[3:2];
        acc     = bus_valid && !bus_ack;
        rd      = acc && !bus_we;
        wr      = acc && bus_we;
        empty   = count == '0;
        full    = count == (ADDR_W+1)'(DEPTH);
        flush   = wr && reg_sel == 2'd2 && bus_wdata[9];
        pop     = rd && reg_sel == 2'd0 && !empty;
        // a pop frees the slot, so a push into a full FIFO still succeeds
        push    = res_valid && (!full || pop);
        status  = {20'b0, underflow, overflow, full, empty, 8'(count)};
        ctrl    = {22'b0, irq_en, thresh};
        rd_val  = reg_sel == 2'd0 ? (empty ? 32'b0 : 32'(mem[rd_ptr])) :
                  reg_sel == 2'd1 ? status :
                  reg_sel == 2'd2 ? ctrl : 32'b0;
    end

    assign irq = irq_en && thresh != '0 && 8'(count) >= thresh;

    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= res_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            thresh    <= 8'(THRESH);
            irq_en    <= 1'b0;
        end else begin
            bus_ack <= acc;
            if (rd) bus_rdata <= rd_val;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            end
            if (res_valid && full && !pop && !flush) overflow <= 1'b1;
            else if (wr && reg_sel == 2'd1 && bus_wdata[10]) overflow <= 1'b0;
            if (rd && reg_sel == 2'd0 && empty) underflow <= 1'b1;
            else if (wr && reg_sel == 2'd1 && bus_wdata[11]) underflow <= 1'b0;
            if (wr && reg_sel == 2'd2) begin
                thresh <= bus_wdata[7:0];
                irq_en <= bus_wdata[8];
            end
        end
    end
endmodule
